// File: rtl/mxv_pkg.sv
// rtl/mxv_pkg.sv - shared types, command codes, selector codes and FSM states for the MxV control unit
package mxv_pkg;

    localparam int MXV_MAX_N  = 4;
    localparam int MXV_DATA_W = 8;

    typedef logic [MXV_DATA_W-1:0] data_uart_t;
    typedef logic [MXV_DATA_W-1:0] val_t;
    typedef logic [MXV_MAX_N-1:0]  push_pop_t;
    typedef logic [2:0]            sltr_8_t;
    typedef logic [1:0]            sltr_2_t;

    localparam val_t CMD_SIZE  = 8'h01;
    localparam val_t CMD_START = 8'h03;
    localparam val_t CMD_DATA  = 8'h04;

    localparam sltr_2_t PE_HOLD  = 2'b00;
    localparam sltr_2_t PE_CLEAR = 2'b01;
    localparam sltr_2_t PE_ACC   = 2'b10;
    localparam sltr_2_t PE_DRIVE = 2'b11;

    localparam sltr_8_t VAL_NONE = 3'd0;
    localparam sltr_8_t VAL_VEC  = 3'd5;

    localparam data_uart_t CH_E   = 8'h45;
    localparam data_uart_t CH_F   = 8'h46;
    localparam data_uart_t CH_SEP = 8'h5F;

    typedef enum logic [3:0] {
        ST_IDLE, ST_SOF, ST_LEN, ST_CMD, ST_PAYLOAD,
        ST_EOF1, ST_EOF2, ST_COMPUTE, ST_RESULT, ST_READOUT
    } state_t;

    // Upper-case hex only: '0'-'9', 'A'-'F'.
    function automatic logic is_hex(input data_uart_t c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46);
    endfunction

    function automatic logic [3:0] hex_nib(input data_uart_t c);
        return (c <= 8'h39) ? c[3:0] : c[3:0] + 4'd9;
    endfunction

endpackage

// File: rtl/mxv_frame_parser.sv
// rtl/mxv_frame_parser.sv - ASCII-hex frame parser: header/terminator FSM, byte assembly, frame checks
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rcv, data           character strobe and character (already gated by the sequencer)
//   n, matrix_loaded    current size and load state, used to check the data-frame length
//   byte_valid, dbyte   one-cycle pulse for each data payload byte; dbyte holds last decoded byte
//   cmd                 command byte of the current/last frame
//   frame_done          one-cycle pulse after a well-formed 'E','F' terminator
//   frame_abort         one-cycle pulse when a frame is rejected
module mxv_frame_parser
    import mxv_pkg::*;
#(
    parameter int MAX_N  = MXV_MAX_N,
    parameter int DATA_W = MXV_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rcv,
    input  logic [DATA_W-1:0] data,
    input  logic [2:0]        n,
    input  logic              matrix_loaded,
    output logic              byte_valid,
    output val_t              dbyte,
    output val_t              cmd,
    output logic              frame_done,
    output logic              frame_abort
);

    state_t     state, state_nxt;
    logic       hi_seen;
    logic [3:0] hi_nib;
    val_t       len;
    val_t       pay_cnt;
    logic       abort, done, data_byte;

    logic ch_hex, digit_st;
    val_t nib_byte, exp_len;

    assign ch_hex   = is_hex(data);
    assign digit_st = (state == ST_LEN) || (state == ST_CMD) || (state == ST_PAYLOAD);
    assign nib_byte = {hi_nib, hex_nib(data)};
    // A matrix frame carries N*N bytes, a vector frame N bytes.
    assign exp_len  = matrix_loaded ? {5'd0, n} : {5'd0, n} * {5'd0, n};

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        done      = 1'b0;
        data_byte = 1'b0;
        if (rcv && !(data == CH_SEP && state != ST_IDLE)) begin
            case (state)
                ST_IDLE: if (data == CH_F) state_nxt = ST_SOF;
                ST_SOF:  state_nxt = (data == CH_E) ? ST_LEN : ST_IDLE;
                ST_LEN: begin
                    if (!ch_hex)      abort = 1'b1;
                    else if (hi_seen) state_nxt = ST_CMD;
                end
                ST_CMD: begin
                    if (!ch_hex) abort = 1'b1;
                    else if (hi_seen) begin
                        case (nib_byte)
                            CMD_SIZE:  if (len == 8'd2) state_nxt = ST_PAYLOAD; else abort = 1'b1;
                            CMD_START: if (len == 8'd1) state_nxt = ST_EOF1;    else abort = 1'b1;
                            CMD_DATA:  if (n != 3'd0 && len == exp_len) state_nxt = ST_PAYLOAD;
                                       else abort = 1'b1;
                            default:   abort = 1'b1;
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    if (!ch_hex) abort = 1'b1;
                    else if (hi_seen) begin
                        if (cmd == CMD_SIZE) begin
                            if (nib_byte >= 8'd1 && nib_byte <= 8'(MAX_N)) state_nxt = ST_EOF1;
                            else abort = 1'b1;
                        end else begin
                            data_byte = 1'b1;
                            if (pay_cnt == len - 8'd1) state_nxt = ST_EOF1;
                        end
                    end
                end
                ST_EOF1: if (data == CH_E) state_nxt = ST_EOF2; else abort = 1'b1;
                ST_EOF2: begin
                    if (data == CH_F) begin
                        done      = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        abort = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        if (abort) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            hi_seen     <= 1'b0;
            hi_nib      <= 4'd0;
            len         <= '0;
            cmd         <= '0;
            dbyte       <= '0;
            pay_cnt     <= '0;
            byte_valid  <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_nxt;
            byte_valid  <= data_byte;
            frame_done  <= done;
            frame_abort <= abort;
            if (abort) begin
                hi_seen <= 1'b0;
            end else if (rcv && digit_st && ch_hex) begin
                if (!hi_seen) begin
                    hi_seen <= 1'b1;
                    hi_nib  <= hex_nib(data);
                end else begin
                    hi_seen <= 1'b0;
                    dbyte   <= nib_byte;
                    if (state == ST_LEN) len <= nib_byte;
                    if (state == ST_CMD) cmd <= nib_byte;
                end
            end
            if (state == ST_CMD)  pay_cnt <= '0;
            else if (data_byte)   pay_cnt <= pay_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/mxv_ctrl_top.sv
// rtl/mxv_ctrl_top.sv - MxV accelerator control: frame commit, FIFO routing and compute/result/readout sequencing
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   rcv, data                    UART character strobe and character
//   push_matrix, push_vector     load strobes for row FIFOs / vector FIFO, val is the data
//   pop_matrix, pop_vector       operand pops during accumulation
//   push_result, pop_result      result FIFO push (per PE) and read-out pops
//   val, dmx_val_sltr            last decoded byte and its routing code
//   dmx_a_sltr..dmx_d_sltr       PE operation selectors
module mxv_ctrl_top
    import mxv_pkg::*;
#(
    parameter int MAX_N  = MXV_MAX_N,
    parameter int DATA_W = MXV_DATA_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rcv,
    input  data_uart_t data,
    output logic       push_result,
    output logic       pop_result,
    output logic       push_vector,
    output logic       pop_vector,
    output push_pop_t  push_matrix,
    output push_pop_t  pop_matrix,
    output val_t       val,
    output sltr_8_t    dmx_val_sltr,
    output sltr_2_t    dmx_a_sltr,
    output sltr_2_t    dmx_b_sltr,
    output sltr_2_t    dmx_c_sltr,
    output sltr_2_t    dmx_d_sltr
);

    state_t     state, state_nxt;
    logic [2:0] n, cnt, col;
    logic [1:0] row;
    logic       matrix_loaded, vector_loaded;
    logic       byte_valid, frame_done, frame_abort;
    val_t       cmd;
    sltr_2_t    pe_sel [MAX_N];

    // Characters arriving while the datapath is busy are dropped.
    mxv_frame_parser #(.MAX_N(MAX_N), .DATA_W(DATA_W)) u_parser (
        .clk           (clk),
        .rst           (rst),
        .rcv           (rcv && state == ST_IDLE),
        .data          (data),
        .n             (n),
        .matrix_loaded (matrix_loaded),
        .byte_valid    (byte_valid),
        .dbyte         (val),
        .cmd           (cmd),
        .frame_done    (frame_done),
        .frame_abort   (frame_abort)
    );

    // Payload routing: matrix bytes fill rows in order, vector bytes go to the vector FIFO.
    always_comb begin
        push_matrix  = '0;
        push_vector  = 1'b0;
        dmx_val_sltr = VAL_NONE;
        if (byte_valid) begin
            if (matrix_loaded) begin
                push_vector  = 1'b1;
                dmx_val_sltr = VAL_VEC;
            end else begin
                push_matrix[row] = 1'b1;
                dmx_val_sltr     = sltr_8_t'({1'b0, row} + 3'd1);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        pop_vector  = 1'b0;
        pop_matrix  = '0;
        push_result = 1'b0;
        pop_result  = 1'b0;
        pe_sel      = '{default: PE_HOLD};
        case (state)
            ST_IDLE: if (vector_loaded) state_nxt = ST_COMPUTE;
            ST_COMPUTE: begin
                // cnt 0 clears the active PEs, cnt 1..N accumulates one column each.
                for (int i = 0; i < MAX_N; i++) begin
                    if (3'(i) < n) begin
                        pe_sel[i] = (cnt == 3'd0) ? PE_CLEAR : PE_ACC;
                        if (cnt != 3'd0) pop_matrix[i] = 1'b1;
                    end
                end
                pop_vector = (cnt != 3'd0);
                if (cnt == n) state_nxt = ST_RESULT;
            end
            ST_RESULT: begin
                pe_sel[cnt[1:0]] = PE_DRIVE;
                push_result      = 1'b1;
                if (cnt == n - 3'd1) state_nxt = ST_READOUT;
            end
            ST_READOUT: begin
                pop_result = 1'b1;
                if (cnt == n - 3'd1) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign dmx_a_sltr = pe_sel[0];
    assign dmx_b_sltr = pe_sel[1];
    assign dmx_c_sltr = pe_sel[2];
    assign dmx_d_sltr = pe_sel[3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            n             <= '0;
            row           <= '0;
            col           <= '0;
            matrix_loaded <= 1'b0;
            vector_loaded <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)  cnt <= '0;
            else if (state != ST_IDLE) cnt <= cnt + 3'd1;

            if (frame_done || frame_abort) begin
                row <= '0;
                col <= '0;
            end else if (byte_valid) begin
                if (col == n - 3'd1) begin
                    col <= '0;
                    row <= row + 2'd1;
                end else begin
                    col <= col + 3'd1;
                end
            end

            if (frame_done) begin
                case (cmd)
                    CMD_SIZE: begin
                        n             <= val[2:0];
                        matrix_loaded <= 1'b0;
                        vector_loaded <= 1'b0;
                    end
                    CMD_START: begin
                        matrix_loaded <= 1'b0;
                        vector_loaded <= 1'b0;
                    end
                    CMD_DATA: begin
                        if (matrix_loaded) vector_loaded <= 1'b1;
                        else               matrix_loaded <= 1'b1;
                    end
                    default: ;
                endcase
            end

            if (state == ST_READOUT && state_nxt == ST_IDLE) begin
                matrix_loaded <= 1'b0;
                vector_loaded <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mxv_ctrl_top.sv
// tb/tb_mxv_ctrl_top.sv - directed self-checking bench for mxv_ctrl_top
module tb_mxv_ctrl_top;
    import mxv_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rcv = 1'b0;
    data_uart_t data = '0;
    logic       push_result, pop_result, push_vector, pop_vector;
    push_pop_t  push_matrix, pop_matrix;
    val_t       val;
    sltr_8_t    dmx_val_sltr;
    sltr_2_t    dmx_a_sltr, dmx_b_sltr, dmx_c_sltr, dmx_d_sltr;

    mxv_ctrl_top dut (
        .clk          (clk),
        .rst          (rst),
        .rcv          (rcv),
        .data         (data),
        .push_result  (push_result),
        .pop_result   (pop_result),
        .push_vector  (push_vector),
        .pop_vector   (pop_vector),
        .push_matrix  (push_matrix),
        .pop_matrix   (pop_matrix),
        .val          (val),
        .dmx_val_sltr (dmx_val_sltr),
        .dmx_a_sltr   (dmx_a_sltr),
        .dmx_b_sltr   (dmx_b_sltr),
        .dmx_c_sltr   (dmx_c_sltr),
        .dmx_d_sltr   (dmx_d_sltr)
    );

    always #5 clk = ~clk;

    int num_checks = 0;
    int num_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        num_checks++;
        if (got !== exp) begin
            num_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // push log entry: {push_vector, push_matrix[3:0], dmx_val_sltr[2:0], val[7:0]}
    logic [15:0] push_log [$];
    // activity entry: {pop_vector, pop_matrix[3:0], push_result, pop_result, a, b, c, d}
    logic [14:0] act_log  [$];
    int          act_cyc  [$];
    int          cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            logic [14:0] a;
            if (push_vector || push_matrix != 4'b0000)
                push_log.push_back({push_vector, push_matrix, dmx_val_sltr, val});
            a = {pop_vector, pop_matrix, push_result, pop_result,
                 dmx_a_sltr, dmx_b_sltr, dmx_c_sltr, dmx_d_sltr};
            if (a != 15'd0) begin
                act_log.push_back(a);
                act_cyc.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic send_char(input logic [7:0] c);
        @(posedge clk); #1;
        rcv  = 1'b1;
        data = c;
        @(posedge clk); #1;
        rcv  = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    logic [30:0] all_outs;
    assign all_outs = {push_result, pop_result, push_vector, pop_vector, push_matrix, pop_matrix,
                       val, dmx_val_sltr, dmx_a_sltr, dmx_b_sltr, dmx_c_sltr, dmx_d_sltr};

    logic [14:0] exp_act [10];
    int          p0, a0;

    initial begin
        exp_act[0] = {1'b0, 4'b0000, 1'b0, 1'b0, 2'b01, 2'b01, 2'b01, 2'b00};
        exp_act[1] = {1'b1, 4'b0111, 1'b0, 1'b0, 2'b10, 2'b10, 2'b10, 2'b00};
        exp_act[2] = exp_act[1];
        exp_act[3] = exp_act[1];
        exp_act[4] = {1'b0, 4'b0000, 1'b1, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00};
        exp_act[5] = {1'b0, 4'b0000, 1'b1, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00};
        exp_act[6] = {1'b0, 4'b0000, 1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00};
        exp_act[7] = {1'b0, 4'b0000, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        exp_act[8] = exp_act[7];
        exp_act[9] = exp_act[7];

        // reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", 32'(all_outs), 32'd0);
        check("reset_n", 32'(dut.n), 32'd0);
        check("reset_flags", {30'd0, dut.matrix_loaded, dut.vector_loaded}, 32'd0);
        check("reset_state", 32'(dut.state), 32'(ST_IDLE));

        // set size N=3
        send_str("FE_02_01_03_EF");
        idle(4);
        check("size_n", 32'(dut.n), 32'd3);
        check("size_no_push", 32'(push_log.size()), 32'd0);
        check("size_no_act", 32'(act_log.size()), 32'd0);

        // start transfer, then 3x3 matrix
        send_str("FE_01_03_EF");
        send_str("FE_09_04_010203_010203_010203_EF");
        idle(4);
        check("mat_push_count", 32'(push_log.size()), 32'd9);
        for (int k = 0; k < 9 && k < push_log.size(); k++) begin
            logic [15:0] e;
            e = {1'b0, 4'(1 << (k / 3)), 3'(k / 3 + 1), 8'(k % 3 + 1)};
            check($sformatf("mat_push_%0d", k), 32'(push_log[k]), 32'(e));
        end
        check("mat_loaded", {30'd0, dut.matrix_loaded, dut.vector_loaded}, 32'd2);

        // vector frame and full compute sequence
        send_str("FE_03_04_040404_EF");
        idle(30);
        check("vec_push_count", 32'(push_log.size()), 32'd12);
        for (int k = 9; k < 12 && k < push_log.size(); k++)
            check($sformatf("vec_push_%0d", k - 9), 32'(push_log[k]),
                  32'({1'b1, 4'b0000, 3'd5, 8'h04}));
        check("act_count", 32'(act_log.size()), 32'd10);
        for (int k = 0; k < 10 && k < act_log.size(); k++) begin
            check($sformatf("act_%0d", k), 32'(act_log[k]), 32'(exp_act[k]));
            check($sformatf("act_cyc_%0d", k), 32'(act_cyc[k] - act_cyc[0]), 32'(k));
        end
        check("post_compute_state", 32'(dut.state), 32'(ST_IDLE));
        check("post_compute_flags", {30'd0, dut.matrix_loaded, dut.vector_loaded}, 32'd0);
        check("post_compute_n", 32'(dut.n), 32'd3);

        // wrong length for a 3x3 matrix; trailing 'F' is flushed by a non-'E' character
        p0 = push_log.size();
        a0 = act_log.size();
        send_str("FE_08_04_0102030405060708_EF");
        send_str("Z");
        idle(4);
        check("badlen_no_push", 32'(push_log.size() - p0), 32'd0);
        check("badlen_flags", {30'd0, dut.matrix_loaded, dut.vector_loaded}, 32'd0);
        check("badlen_state", 32'(dut.state), 32'(ST_IDLE));
        send_str("FE_09_04_0A0B0C_0D0E0F_101112_EF");
        idle(4);
        check("goodmat_push_count", 32'(push_log.size() - p0), 32'd9);
        if (push_log.size() > 0)
            check("goodmat_last", 32'(push_log[push_log.size() - 1]),
                  32'({1'b0, 4'b0100, 3'd3, 8'h12}));
        check("goodmat_flags", {30'd0, dut.matrix_loaded, dut.vector_loaded}, 32'd2);

        // illegal character inside a vector payload
        p0 = push_log.size();
        send_str("FE_03_04_05G");
        idle(4);
        check("badchar_push_count", 32'(push_log.size() - p0), 32'd1);
        if (push_log.size() > p0)
            check("badchar_push", 32'(push_log[p0]), 32'({1'b1, 4'b0000, 3'd5, 8'h05}));
        check("badchar_state", 32'(dut.state), 32'(ST_IDLE));
        check("badchar_flags", {30'd0, dut.matrix_loaded, dut.vector_loaded}, 32'd2);
        check("badchar_no_act", 32'(act_log.size() - a0), 32'd0);

        // next frame parses normally, then reset lands mid-COMPUTE
        p0 = push_log.size();
        send_str("FE_03_04_010101_EF");
        for (int i = 0; i < 40 && dut.state != ST_COMPUTE; i++) idle(1);
        check("reach_compute", 32'(dut.state), 32'(ST_COMPUTE));
        check("resync_push_count", 32'(push_log.size() - p0), 32'd3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_outputs", 32'(all_outs), 32'd0);
        check("midrst_state", 32'(dut.state), 32'(ST_IDLE));
        check("midrst_n", 32'(dut.n), 32'd0);
        check("midrst_flags", {30'd0, dut.matrix_loaded, dut.vector_loaded}, 32'd0);
        #1 rst = 1'b0;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
